// File: rtl/lsu_mem_unit.sv
// Load/store unit: accepts one load or store per handshake and runs a
// valid/ready access to data memory. It handles byte/half/word/dword sizing,
// byte enables, sign/zero extension and misalignment errors.
//
// Optional feature macro: LSU_TIMEOUT_EN. When it is defined, a bus-wait
// counter aborts the access with resp_err after TIMEOUT_CYCLES cycles in
// REQ/WAIT. When it is undefined, the unit waits indefinitely.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   req_valid/req_ready       request handshake; req_ready is high only in IDLE
//   req_we, req_size,         request fields: store flag, size code,
//   req_unsigned, req_addr,   zero-extend flag, byte address and
//   req_wdata                 LSB-justified store data
//   mem_valid/mem_ready       bus request handshake
//   mem_we, mem_addr,         bus write flag, aligned address,
//   mem_be, mem_wdata         byte enables and lane-shifted store data
//   mem_rvalid, mem_rdata     read data return
//   resp_valid, resp_rdata,   one-cycle completion pulse, extended load data
//   resp_err                  and error flag
//   busy                      unit is not idle
module lsu_mem_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                resp_err,
  output logic                busy
);

  localparam int unsigned NumBytes = XLEN / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [1:0]          size_q, size_d;
  logic                unsigned_q, unsigned_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [OffW-1:0]     off;
  logic [NumBytes-1:0] be_base;
  logic [XLEN-1:0]     shifted;
  logic [XLEN-1:0]     load_ext;
  logic                ext_sign;
  logic [2:0]          req_mask;
  logic                req_bad;
  int unsigned         sb;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT_CYCLES);
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  assign off = addr_q[OffW-1:0];

  // Dword is only legal when the bus is 64 bits wide.
  assign req_mask = (3'b001 << req_size) - 3'b001;
  assign req_bad  = ((req_size == 2'b11) && (XLEN < 64)) || (|(req_addr[2:0] & req_mask));

  // Byte enables and load extension for the latched size/offset.
  always_comb begin
    sb       = 32'd1 << size_q;
    be_base  = '0;
    ext_sign = 1'b0;
    shifted  = mem_rdata >> {off, 3'b000};
    load_ext = '0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      be_base[i] = (i < sb);
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      if (i == 8 * sb - 1) ext_sign = shifted[i] & ~unsigned_q;
    end
    for (int unsigned i = 0; i < XLEN; i++) begin
      load_ext[i] = (i < 8 * sb) ? shifted[i] : ext_sign;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
`ifdef LSU_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d       = req_we;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rdata_d    = '0;
          err_d      = req_bad;
          state_d    = req_bad ? StResp : StReq;
`ifdef LSU_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      StReq: begin
        if (mem_ready) begin
          state_d = we_q ? StResp : StWait;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_inc == Limit) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
        cnt_d = cnt_inc;
`endif
      end
      StWait: begin
        if (mem_rvalid) begin
          rdata_d = load_ext;
          state_d = StResp;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_inc == Limit) begin
          state_d = StResp;
          err_d   = 1'b1;
        end
        cnt_d = cnt_inc;
`endif
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q      <= cnt_d;
`endif
    end
  end

  // Bus and response outputs are gated by state so they read 0 outside use.
  always_comb begin
    req_ready  = (state_q == StIdle);
    busy       = (state_q != StIdle);
    mem_valid  = (state_q == StReq);
    mem_we     = mem_valid & we_q;
    mem_addr   = mem_valid ? {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}} : '0;
    mem_be     = mem_valid ? (be_base << off) : '0;
    mem_wdata  = mem_valid ? (wdata_q << {off, 3'b000}) : '0;
    resp_valid = (state_q == StResp);
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_err   = resp_valid & err_q;
  end

endmodule

// File: tb/tb_lsu_mem_unit.sv
module tb_lsu_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        w_req_valid, w_req_ready, w_req_we, w_req_unsigned;
  logic [1:0]  w_req_size;
  logic [31:0] w_req_addr;
  logic [63:0] w_req_wdata;
  logic        w_mem_valid, w_mem_ready, w_mem_we, w_mem_rvalid;
  logic [31:0] w_mem_addr;
  logic [63:0] w_mem_wdata, w_mem_rdata;
  logic [7:0]  w_mem_be;
  logic        w_resp_valid, w_resp_err, w_busy;
  logic [63:0] w_resp_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_mem_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  lsu_mem_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYCLES(4)) dut64 (
    .clk(clk), .rst(rst),
    .req_valid(w_req_valid), .req_ready(w_req_ready), .req_we(w_req_we),
    .req_size(w_req_size), .req_unsigned(w_req_unsigned), .req_addr(w_req_addr),
    .req_wdata(w_req_wdata),
    .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_we(w_mem_we),
    .mem_addr(w_mem_addr), .mem_be(w_mem_be), .mem_wdata(w_mem_wdata),
    .mem_rvalid(w_mem_rvalid), .mem_rdata(w_mem_rdata),
    .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .resp_err(w_resp_err),
    .busy(w_busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Zero-wait load on the 32-bit unit; request accepted in the calling cycle.
  task automatic run_load(input string tag, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] rd,
                          input logic [3:0] be, input logic [31:0] exp);
    logic [31:0] al;
    al = addr & 32'hFFFF_FFFC;
    req_valid = 1'b1; req_we = 1'b0; req_size = size; req_unsigned = uns; req_addr = addr;
    tick();
    req_valid = 1'b0; req_addr = 32'h0;
    check_eq({tag, " mem_valid"}, 64'(mem_valid), 64'd1);
    check_eq({tag, " mem_we"}, 64'(mem_we), 64'd0);
    check_eq({tag, " mem_be"}, 64'(mem_be), 64'(be));
    check_eq({tag, " mem_addr"}, 64'(mem_addr), 64'(al));
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    check_eq({tag, " wait no resp"}, 64'(resp_valid), 64'd0);
    check_eq({tag, " wait mem_valid"}, 64'(mem_valid), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = rd;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check_eq({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check_eq({tag, " resp_rdata"}, 64'(resp_rdata), 64'(exp));
    check_eq({tag, " resp_err"}, 64'(resp_err), 64'd0);
    tick();
    check_eq({tag, " resp pulse"}, 64'(resp_valid), 64'd0);
    check_eq({tag, " ready"}, 64'(req_ready), 64'd1);
  endtask

  // Request that must fail at decode: response at N+1, no bus access.
  task automatic run_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
    req_valid = 1'b1; req_we = 1'b0; req_size = size; req_unsigned = 1'b0; req_addr = addr;
    tick();
    req_valid = 1'b0;
    check_eq({tag, " no mem_valid"}, 64'(mem_valid), 64'd0);
    check_eq({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
    check_eq({tag, " resp_err"}, 64'(resp_err), 64'd1);
    check_eq({tag, " resp_rdata"}, 64'(resp_rdata), 64'd0);
    tick();
    check_eq({tag, " ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    w_req_valid = 1'b0; w_req_we = 1'b0; w_req_size = 2'b00; w_req_unsigned = 1'b0;
    w_req_addr = 32'h0; w_req_wdata = 64'h0;
    w_mem_ready = 1'b0; w_mem_rvalid = 1'b0; w_mem_rdata = 64'h0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("reset req_ready", 64'(req_ready), 64'd1);
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset mem_valid", 64'(mem_valid), 64'd0);
    check_eq("reset resp_valid", 64'(resp_valid), 64'd0);

    run_load("lw", 2'b10, 1'b0, 32'h100, 32'hDEAD_BEEF, 4'hF, 32'hDEAD_BEEF);
    run_load("lb", 2'b00, 1'b0, 32'h103, 32'h8012_3456, 4'h8, 32'hFFFF_FF80);
    run_load("lbu", 2'b00, 1'b1, 32'h103, 32'h8012_3456, 4'h8, 32'h0000_0080);
    run_load("lh", 2'b01, 1'b0, 32'h102, 32'h8001_5555, 4'hC, 32'hFFFF_8001);
    run_load("lhu", 2'b01, 1'b1, 32'h100, 32'h1234_9ABC, 4'h3, 32'h0000_9ABC);

    // Half store with mem_ready held low for three REQ cycles.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_addr = 32'h102;
    req_wdata = 32'h0000_1234;
    tick();
    req_valid = 1'b0; req_wdata = 32'h0;
    for (int i = 0; i < 4; i++) begin
      check_eq("sh mem_valid", 64'(mem_valid), 64'd1);
      check_eq("sh mem_we", 64'(mem_we), 64'd1);
      check_eq("sh mem_be", 64'(mem_be), 64'hC);
      check_eq("sh mem_wdata", 64'(mem_wdata), 64'h1234_0000);
      check_eq("sh mem_addr", 64'(mem_addr), 64'h100);
      check_eq("sh busy", 64'(busy), 64'd1);
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    check_eq("sh resp_valid", 64'(resp_valid), 64'd1);
    check_eq("sh resp_err", 64'(resp_err), 64'd0);
    check_eq("sh resp_rdata", 64'(resp_rdata), 64'd0);
    tick();
    check_eq("sh ready", 64'(req_ready), 64'd1);

    run_err("misaligned lw", 2'b10, 32'h101);
    run_err("misaligned lh", 2'b01, 32'h103);
    run_err("dword on 32", 2'b11, 32'h0);

    // Stray read data in IDLE must not produce a response.
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    check_eq("idle rvalid ignored", 64'(resp_valid), 64'd0);

    // Reset mid-access aborts; a late rvalid afterwards is ignored.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h300;
    tick();
    req_valid = 1'b0;
    check_eq("abort in req", 64'(mem_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort mem_valid", 64'(mem_valid), 64'd0);
    check_eq("abort ready", 64'(req_ready), 64'd1);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check_eq("abort late rvalid", 64'(resp_valid), 64'd0);

`ifdef LSU_TIMEOUT_EN
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h200;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("to mem_valid", 64'(mem_valid), 64'd1);
      tick();
    end
    check_eq("to mem_valid drop", 64'(mem_valid), 64'd0);
    check_eq("to resp_valid", 64'(resp_valid), 64'd1);
    check_eq("to resp_err", 64'(resp_err), 64'd1);
    check_eq("to resp_rdata", 64'(resp_rdata), 64'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    check_eq("to ready", 64'(req_ready), 64'd1);
    check_eq("to late rvalid", 64'(resp_valid), 64'd0);
    tick();
    check_eq("to late rvalid 2", 64'(resp_valid), 64'd0);
`endif

    // 64-bit unit: dword load at 0x8, then a signed word from the upper lane.
    w_req_valid = 1'b1; w_req_size = 2'b11; w_req_addr = 32'h8;
    tick();
    w_req_valid = 1'b0;
    check_eq("ld mem_be", 64'(w_mem_be), 64'hFF);
    check_eq("ld mem_addr", 64'(w_mem_addr), 64'h8);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    w_mem_rvalid = 1'b1; w_mem_rdata = 64'h0123_4567_89AB_CDEF;
    tick();
    w_mem_rvalid = 1'b0;
    check_eq("ld resp_valid", 64'(w_resp_valid), 64'd1);
    check_eq("ld resp_err", 64'(w_resp_err), 64'd0);
    check_eq("ld resp_rdata", w_resp_rdata, 64'h0123_4567_89AB_CDEF);
    tick();
    w_req_valid = 1'b1; w_req_size = 2'b10; w_req_unsigned = 1'b0; w_req_addr = 32'hC;
    tick();
    w_req_valid = 1'b0;
    check_eq("lw64 mem_be", 64'(w_mem_be), 64'hF0);
    check_eq("lw64 mem_addr", 64'(w_mem_addr), 64'h8);
    w_mem_ready = 1'b1;
    tick();
    w_mem_ready = 1'b0;
    w_mem_rvalid = 1'b1; w_mem_rdata = 64'h8000_0000_1111_1111;
    tick();
    w_mem_rvalid = 1'b0;
    check_eq("lw64 resp_rdata", w_resp_rdata, 64'hFFFF_FFFF_8000_0000);
    tick();
    check_eq("lw64 ready", 64'(w_req_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
